// File: rtl/serializer12_pkg.sv
// serializer12_pkg: state encoding and default word width for the serializer
package serializer12_pkg;
  localparam int WIDTH_DEF = 12;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/serializer12_if.sv
// serializer12_if: load handshake, shift enable and serial outputs of the serializer
interface serializer12_if #(parameter int WIDTH = serializer12_pkg::WIDTH_DEF);
  logic [WIDTH-1:0] data_in;
  logic load;
  logic ready;
  logic en;
  logic sout;
  logic sout_valid;
  logic busy;
  logic done;
  modport master (output data_in, load, en, input ready, sout, sout_valid, busy, done);
  modport slave (input data_in, load, en, output ready, sout, sout_valid, busy, done);
endinterface

// File: rtl/serializer12_shift_reg12.sv
// shift_reg12: loadable shift register, zero-filling toward the selected output end
module shift_reg12 #(
  parameter int WIDTH = serializer12_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic             lsb_first,
  input  logic [WIDTH-1:0] pin,
  output logic             sout
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  always_comb begin
    shreg_d = load ? pin : shift_en ? (lsb_first ? shreg_q >> 1 : shreg_q << 1) : shreg_q;
    sout = lsb_first ? shreg_q[0] : shreg_q[WIDTH-1];
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) shreg_q <= '0;
    else shreg_q <= shreg_d;
endmodule

// File: rtl/serializer12.sv
// serializer12: valid/ready loaded parallel-in serial-out transmitter with done pulse
module serializer12
  import serializer12_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic           clk,
  input logic           clr_n,
  serializer12_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, shift, last, ser;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    accept = state_q == IDLE && bus.load;
    shift = state_q == SHIFT && bus.en;
    last = cnt_q == CW'(WIDTH - 1);
    state_d = accept ? SHIFT : (shift && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
    cnt_d = accept ? '0 : (shift && !last) ? cnt_q + 1'b1 : cnt_q;
  end
  // outputs depend on registered state only; sout is forced low outside SHIFT
  always_comb begin
    bus.ready = state_q == IDLE;
    bus.sout_valid = state_q == SHIFT;
    bus.sout = state_q == SHIFT && ser;
    bus.busy = state_q == SHIFT || state_q == DONE;
    bus.done = state_q == DONE;
  end
  shift_reg12 #(.WIDTH(WIDTH)) u_shreg (
    .clk(clk),
    .clr_n(clr_n),
    .load(accept),
    .shift_en(shift),
    .lsb_first(LSB_FIRST),
    .pin(bus.data_in),
    .sout(ser)
  );
endmodule

// File: tb/tb_serializer12.sv
// tb_serializer12: vector table, corner sequences and random traffic against a bit-index model
module tb_serializer12;
  import serializer12_pkg::*;
  logic clk = 1'b0;
  logic clr_n;
  logic load, en;
  logic [11:0] data_in;
  int checks = 0, errors = 0;
  bit mon = 1'b0;
  int pos = -1;
  logic [11:0] w = '0;
  always #5 clk = ~clk;
  serializer12_if #(.WIDTH(12)) ifa ();
  serializer12_if #(.WIDTH(12)) ifb ();
  assign ifa.load = load;
  assign ifa.en = en;
  assign ifa.data_in = data_in;
  assign ifb.load = load;
  assign ifb.en = en;
  assign ifb.data_in = data_in;
  serializer12 #(.WIDTH(12), .LSB_FIRST(1'b0)) dut_a (.clk(clk), .clr_n(clr_n), .bus(ifa.slave));
  serializer12 #(.WIDTH(12), .LSB_FIRST(1'b1)) dut_b (.clk(clr_n ? clk : clk), .clr_n(clr_n), .bus(ifb.slave));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // pos: -1 idle, 0..11 index of the bit on the wire, 12 the done cycle
  always @(posedge clk or negedge clr_n)
    if (!clr_n) pos <= -1;
    else if (pos < 0) begin
      if (load) begin
        pos <= 0;
        w <= data_in;
      end
    end else if (pos == 12) pos <= -1;
    else if (en) pos <= pos + 1;
  function automatic logic exp_sout(input bit lsb);
    if (pos < 0 || pos > 11) return 1'b0;
    return lsb ? w[pos] : w[11-pos];
  endfunction
  always @(negedge clk)
    if (mon) begin
      chk("a_ready", ifa.ready, pos < 0);
      chk("a_busy", ifa.busy, pos >= 0);
      chk("a_done", ifa.done, pos == 12);
      chk("a_valid", ifa.sout_valid, pos >= 0 && pos < 12);
      chk("a_sout", ifa.sout, exp_sout(1'b0));
      chk("b_ready", ifb.ready, pos < 0);
      chk("b_busy", ifb.busy, pos >= 0);
      chk("b_done", ifb.done, pos == 12);
      chk("b_valid", ifb.sout_valid, pos >= 0 && pos < 12);
      chk("b_sout", ifb.sout, exp_sout(1'b1));
    end
  typedef struct {
    logic ld;
    logic e;
    logic [11:0] d;
    logic s;
    logic v;
    logic dn;
    logic rdy;
  } vec_t;
  vec_t vt[14];
  initial begin
    logic [11:0] wd, ra, rb;
    int n, ones, dn, t1, t2, c;
    clr_n = 1'b0;
    load = 1'b0;
    en = 1'b0;
    data_in = '0;
    #12;
    chk("rst_sout", ifa.sout, 0);
    chk("rst_valid", ifa.sout_valid, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_ready", ifa.ready, 1);
    @(negedge clk);
    clr_n = 1'b1;
    mon = 1'b1;
    wd = 12'hA5C;
    for (int k = 0; k < 14; k++) begin
      vt[k].ld = k == 0;
      vt[k].e = 1'b1;
      vt[k].d = k == 0 ? wd : ~wd;
      vt[k].s = k < 12 ? wd[11-k] : 1'b0;
      vt[k].v = k < 12;
      vt[k].dn = k == 12;
      vt[k].rdy = k == 13;
    end
    for (int k = 0; k < 14; k++) begin
      load = vt[k].ld;
      en = vt[k].e;
      data_in = vt[k].d;
      @(negedge clk);
      chk("vec_sout", ifa.sout, vt[k].s);
      chk("vec_valid", ifa.sout_valid, vt[k].v);
      chk("vec_done", ifa.done, vt[k].dn);
      chk("vec_ready", ifa.ready, vt[k].rdy);
    end
    load = 1'b0;
    data_in = 12'hA5C;
    load = 1'b1;
    en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_sout", ifa.sout, 0);
      chk("stall_valid", ifa.sout_valid, 1);
    end
    en = 1'b1;
    n = 7;
    while (!ifa.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("stall_done_cycle", n, 16);
    @(negedge clk);
    chk("stall_ready", ifa.ready, 1);
    data_in = 12'h000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    data_in = 12'hFFF;
    load = 1'b1;
    ones = 0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) load = 1'b0;
      if (ifa.sout_valid && ifa.sout) ones++;
      if (ifb.sout_valid && ifb.sout) ones++;
      if (ifa.done) dn++;
    end
    chk("busy_load_ones", ones, 0);
    chk("busy_load_dones", dn, 1);
    chk("busy_load_ready", ifa.ready, 1);
    data_in = 12'h3C3;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_sout", ifa.sout, 0);
    chk("abort_valid", ifa.sout_valid, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_done", ifa.done, 0);
    chk("abort_ready", ifa.ready, 1);
    chk("abort_b_busy", ifb.busy, 0);
    @(negedge clk);
    clr_n = 1'b1;
    data_in = 12'h001;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ra = '0;
    rb = '0;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) chk("lsb_first_bit", ifb.sout, 1);
      ra = {ra[10:0], ifa.sout};
      rb = {ifb.sout, rb[11:1]};
      @(negedge clk);
    end
    chk("msb_word", ra, 12'h001);
    chk("lsb_word", rb, 12'h001);
    chk("post_abort_done", ifa.done, 1);
    @(negedge clk);
    data_in = 12'($urandom);
    load = 1'b1;
    en = 1'b1;
    c = 0;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && c < 60) begin
      @(negedge clk);
      c++;
      if (ifa.done) begin
        if (t1 < 0) t1 = c;
        else t2 = c;
      end
    end
    load = 1'b0;
    chk("b2b_spacing", t2 - t1, 14);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 500; k++) begin
      load = $urandom_range(0, 3) == 0;
      en = $urandom_range(0, 3) != 0;
      data_in = 12'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    en = 1'b1;
    repeat (20) @(negedge clk);
    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serializer12.md
Name: serializer12

Overview:
Parallel-in, serial-out transmitter for 12-bit words. It is the unload side of the 12-bit register datapath: it accepts a word through a valid/ready handshake and shifts it out one bit per enabled clock. It also provides a serial-valid qualifier and a completion pulse. It sits between the processor's 12-bit register outputs and any 1-bit serial consumer, such as a debug port or a bit-serial link.

Parameters:
WIDTH, 12, word length in bits; WIDTH >= 2
LSB_FIRST, 0, 0 = shift MSB first; 1 = shift LSB first

Ports:
clk  input  1  system clock; all state updates on the rising edge
clr_n  input  1  reset: one clock; reset is asynchronous and active-low
data_in  input  WIDTH  word to transmit, sampled on the accepted load
load  input  1  load request; valid-style, qualified by ready
ready  output  1  high when a load will be accepted this cycle
en  input  1  shift enable; when low, the serializer holds all state
sout  output  1  current serial bit
sout_valid  output  1  high while sout carries a word bit
busy  output  1  high from the cycle after acceptance through DONE
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE, shift register=0, bit counter=0.
  - Outputs while in reset: sout=0, sout_valid=0, busy=0, done=0, ready=1.
- FSM states: IDLE, SHIFT, DONE. All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - ready=1, sout_valid=0, sout=0.
  - On load=1, capture data_in into the shift register, clear the counter and go to SHIFT. This does not depend on en.
- SHIFT:
  - sout = shreg[WIDTH-1] when LSB_FIRST=0, shreg[0] when LSB_FIRST=1. sout_valid=1, busy=1, ready=0.
  - If en=1: shift by one toward the output end, zero-fill, counter+1.
  - When the counter equals WIDTH-1 with en=1, go to DONE.
  - If en=0: hold the shift register, counter and state. sout and sout_valid stay asserted with the same bit.
- DONE: done=1, busy=1, sout_valid=0, ready=0. Return to IDLE unconditionally on the next clock, regardless of en.
- Latency:
  - Bit 0 appears on sout the cycle after acceptance.
  - With en held high, the last bit appears at acceptance+WIDTH, done at acceptance+WIDTH+1, and ready is high again at acceptance+WIDTH+2.
- load while ready=0 is ignored; data is not queued.
- load and en are independent. en is don't-care in IDLE and DONE.
- Counter width is clog2(WIDTH) bits. The counter never wraps within a word; it is cleared on every accept.
- Reset asserted mid-word aborts the transfer: outputs go to reset values immediately, with no done pulse. After release the block is in IDLE.
- Changes to data_in after acceptance have no effect on the word in flight.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
  - the default word width constant of 12
- Natural sub-module: shift_reg12, a WIDTH-bit loadable shift register.
  - Ports: clk, clr_n, load, shift enable, direction, parallel in, serial out.
  - The FSM and counter stay in serializer12.

Test Plan:
- MSB-first word: reset, then load=1 with data_in=12'hA5C while ready=1, en=1.
  - Required: sout = 1,0,1,0,0,1,0,1,1,1,0,0 on cycles +1..+12 with sout_valid=1; done=1 on cycle +13; ready=1 on cycle +14.
- Stall: same word, en=0 for 3 cycles after the 4th bit.
  - Required: sout holds 0 with sout_valid=1 for those cycles, the remaining bits resume unchanged, and done is delayed by exactly 3 cycles.
- Load while busy: load=1 with data_in=12'hFFF in the middle of a 12'h000 transfer.
  - Required: all 12 bits are 0, done fires once, and 12'hFFF is never transmitted.
- Reset mid-word: drop clr_n after bit 5 of 12'h3C3.
  - Required: sout, sout_valid, busy and done go to 0 without waiting for a clock edge; ready=1. After release, load 12'h001 and the full word transmits correctly.
- LSB-first (LSB_FIRST=1): load 12'h001.
  - Required: sout = 1 then eleven 0s.
- Back-to-back: assert load again on the first cycle ready returns to 1.
  - Required: a new word starts the next cycle, and the spacing between done pulses is WIDTH+2 = 14 cycles.
